// File: rtl/nes_clk_en_gen_pkg.sv
// nes_clk_pkg: shared types and constants for the NES clock-enable generator.
//   state_t      : pause/step controller states
//   MODE_NTSC/PAL: encodings of mode_sel / mode_active
//   *_NTSC/*_PAL : default divisors and M2 low-phase lengths
package nes_clk_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    PAUSED = 2'd2,
    STEP   = 2'd3
  } state_t;

  localparam logic MODE_NTSC = 1'b0;
  localparam logic MODE_PAL  = 1'b1;

  localparam int CPU_DIV_NTSC = 12;
  localparam int PPU_DIV_NTSC = 4;
  localparam int CPU_DIV_PAL  = 16;
  localparam int PPU_DIV_PAL  = 5;

  localparam int M2_LOW_NTSC  = 5;
  localparam int M2_LOW_PAL   = 6;

endpackage

// File: rtl/nes_clk_en_gen_if.sv
// nes_clk_en_gen_if: control/status bundle of the clock-enable generator.
//   run, step_req, mode_sel            : controller -> generator
//   step_ack, mode_active, cpu_ce,
//   ppu_ce, cpu_cycles (, m2)          : generator -> core
// Macro NES_CLK_M2_EN adds the m2 bus-phase signal.
interface nes_clk_en_gen_if #(
  parameter int CYC_W = 16
);
  logic             run;
  logic             step_req;
  logic             step_ack;
  logic             mode_sel;
  logic             mode_active;
  logic             cpu_ce;
  logic             ppu_ce;
  logic [CYC_W-1:0] cpu_cycles;
`ifdef NES_CLK_M2_EN
  logic             m2;
`endif

  modport master (
    output run, step_req, mode_sel,
    input  step_ack, mode_active, cpu_ce, ppu_ce, cpu_cycles
`ifdef NES_CLK_M2_EN
    , input m2
`endif
  );

  modport slave (
    input  run, step_req, mode_sel,
    output step_ack, mode_active, cpu_ce, ppu_ce, cpu_cycles
`ifdef NES_CLK_M2_EN
    , output m2
`endif
  );
endinterface

// File: rtl/nes_clk_en_gen_clk_div_ch.sv
// clk_div_ch: one divider channel. Counts 0..div-1 on each tick and emits a
// registered one-cycle enable when the terminal count is ticked past.
//   m_clk, rst_n : clock, async active-low reset
//   tick         : advance the counter this cycle
//   load_zero    : on a tick, reload 0 instead of advancing
//   div          : current divisor
//   terminal     : cnt == div-1 (combinational)
//   ce           : registered enable pulse
//   cnt          : current count
module clk_div_ch #(
  parameter int CNT_W = 5
) (
  input  logic             m_clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             load_zero,
  input  logic [CNT_W-1:0] div,
  output logic             terminal,
  output logic             ce,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q;

  assign terminal = (cnt_q == div - CNT_W'(1));
  assign cnt      = cnt_q;

  always_ff @(posedge m_clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      ce    <= 1'b0;
    end else if (tick) begin
      ce    <= terminal;
      cnt_q <= (load_zero || terminal) ? '0 : cnt_q + CNT_W'(1);
    end else begin
      ce    <= 1'b0;
    end
  end

endmodule

// File: rtl/nes_clk_en_gen.sv
// nes_clk_en_gen: CPU/PPU clock-enable generator with NTSC/PAL divisor sets,
// boundary-aligned mode switching and debug pause/single-step.
//   m_clk, rst_n : master clock, async active-low reset
//   bus          : nes_clk_en_gen_if.slave (run/step/mode in, enables/status out)
// Macro NES_CLK_M2_EN adds the registered m2 CPU bus-phase output.
//
// state  | meaning
// RUN    | free-running, tick every cycle
// DRAIN  | run dropped; tick until the next CPU boundary, then pause
// PAUSED | no tick; counters just past a boundary
// STEP   | tick until the next CPU boundary, then ack and pause
module nes_clk_en_gen
  import nes_clk_pkg::*;
#(
  parameter int CPU_DIV_A = CPU_DIV_NTSC,
  parameter int PPU_DIV_A = PPU_DIV_NTSC,
  parameter int CPU_DIV_B = CPU_DIV_PAL,
  parameter int PPU_DIV_B = PPU_DIV_PAL,
  parameter int CNT_W     = 5,
  parameter int CYC_W     = 16
`ifdef NES_CLK_M2_EN
  , parameter int M2_LOW_A = M2_LOW_NTSC,
  parameter int M2_LOW_B  = M2_LOW_PAL
`endif
) (
  input logic            m_clk,
  input logic            rst_n,
  nes_clk_en_gen_if.slave bus
);

  state_t           state_q, state_d;
  logic             mode_q, flip_q, pend_q, ack_q;
  logic [CYC_W-1:0] cyc_q;
  logic             tick, ack_d, cpu_term, switch_now;
  logic             cpu_ce, ppu_ce;
  logic [CNT_W-1:0] cpu_div, ppu_div;

  assign cpu_div = (mode_q == MODE_PAL) ? CNT_W'(CPU_DIV_B) : CNT_W'(CPU_DIV_A);
  assign ppu_div = (mode_q == MODE_PAL) ? CNT_W'(PPU_DIV_B) : CNT_W'(PPU_DIV_A);

  // A pending switch lands on a ticked CPU boundary; that boundary's cpu_ce
  // still belongs to the old mode, the new divisors apply from the next edge.
  assign switch_now = tick && cpu_term && pend_q && (state_q != PAUSED);

  always_comb begin
    state_d = state_q;
    tick    = 1'b1;
    ack_d   = 1'b0;
    case (state_q)
      RUN: begin
        // dropping run exactly on a boundary tick pauses right away
        if (!bus.run) state_d = cpu_term ? PAUSED : DRAIN;
      end
      DRAIN: begin
        if (bus.run)       state_d = RUN;
        else if (cpu_term) state_d = PAUSED;
      end
      PAUSED: begin
        // the leaving edge already ticks, so a step is exactly CPU_DIV ticks
        tick = bus.run || bus.step_req;
        if (bus.run)           state_d = RUN;
        else if (bus.step_req) state_d = STEP;
      end
      STEP: begin
        if (bus.run) begin
          state_d = RUN;
        end else if (cpu_term) begin
          state_d = PAUSED;
          ack_d   = 1'b1;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge m_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      mode_q  <= MODE_NTSC;
      flip_q  <= 1'b0;
      pend_q  <= 1'b0;
      ack_q   <= 1'b0;
      cyc_q   <= '0;
    end else begin
      state_q <= state_d;
      flip_q  <= switch_now;
      mode_q  <= mode_q ^ flip_q;
      // mode_q is stale for one edge after a switch; ignore the mismatch then
      pend_q  <= (bus.mode_sel != mode_q) && !switch_now && !flip_q;
      ack_q   <= ack_d;
      if (tick && cpu_term) cyc_q <= cyc_q + CYC_W'(1);
    end
  end

`ifdef NES_CLK_M2_EN
  logic [CNT_W-1:0] cpu_cnt;
  logic [CNT_W-1:0] m2_low;
  logic             m2_q;

  assign m2_low = (mode_q == MODE_PAL) ? CNT_W'(M2_LOW_B) : CNT_W'(M2_LOW_A);

  always_ff @(posedge m_clk or negedge rst_n) begin
    if (!rst_n)    m2_q <= 1'b0;
    else if (tick) m2_q <= (cpu_cnt >= m2_low);
  end

  assign bus.m2 = m2_q;
`endif

  clk_div_ch #(.CNT_W(CNT_W)) u_cpu_div (
    .m_clk     (m_clk),
    .rst_n     (rst_n),
    .tick      (tick),
    .load_zero (switch_now),
    .div       (cpu_div),
    .terminal  (cpu_term),
    .ce        (cpu_ce),
`ifdef NES_CLK_M2_EN
    .cnt       (cpu_cnt)
`else
    .cnt       ()
`endif
  );

  clk_div_ch #(.CNT_W(CNT_W)) u_ppu_div (
    .m_clk     (m_clk),
    .rst_n     (rst_n),
    .tick      (tick),
    .load_zero (switch_now),
    .div       (ppu_div),
    .terminal  (),
    .ce        (ppu_ce),
    .cnt       ()
  );

  assign bus.cpu_ce      = cpu_ce;
  assign bus.ppu_ce      = ppu_ce;
  assign bus.step_ack    = ack_q;
  assign bus.mode_active = mode_q;
  assign bus.cpu_cycles  = cyc_q;

endmodule

// File: tb/tb_nes_clk_en_gen.sv
// Testbench for nes_clk_en_gen. Cycle n is the period after the n-th m_clk
// rising edge following reset release; outputs are sampled 1 ns after the edge.
module tb_nes_clk_en_gen;
  import nes_clk_pkg::*;

  logic m_clk;
  logic rst_n;
  logic rst_n_w;
  int   cyc;
  int   n_chk;
  int   n_pass;

  nes_clk_en_gen_if #(.CYC_W(16)) bus ();
  nes_clk_en_gen_if #(.CYC_W(4))  bus_w ();

  nes_clk_en_gen #(.CYC_W(16)) dut (
    .m_clk (m_clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  nes_clk_en_gen #(.CYC_W(4)) dut_w (
    .m_clk (m_clk),
    .rst_n (rst_n_w),
    .bus   (bus_w)
  );

  initial m_clk = 1'b0;
  always #5 m_clk = ~m_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
  endtask

  task automatic clk_step;
    @(posedge m_clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge m_clk);
    @(negedge m_clk);
    rst_n = 1'b1;
    cyc = 0;
  endtask

  initial begin
    logic e_cpu, e_ppu, e_ack;
    n_chk = 0;
    n_pass = 0;
    cyc = 0;
    rst_n_w = 1'b0;
    bus.run = 1'b1;
    bus.step_req = 1'b0;
    bus.mode_sel = MODE_NTSC;
    bus_w.run = 1'b1;
    bus_w.step_req = 1'b0;
    bus_w.mode_sel = MODE_NTSC;

    // reset values and free-run in mode A
    do_reset();
    #1;
    chk("rst_cpu_ce", 32'(bus.cpu_ce), 32'd0);
    chk("rst_ppu_ce", 32'(bus.ppu_ce), 32'd0);
    chk("rst_ack", 32'(bus.step_ack), 32'd0);
    chk("rst_mode", 32'(bus.mode_active), 32'd0);
    chk("rst_cycles", 32'(bus.cpu_cycles), 32'd0);
    for (int c = 1; c <= 48; c++) begin
      clk_step();
      chk("t1_ppu_ce", 32'(bus.ppu_ce), 32'(c % 4 == 0));
      chk("t1_cpu_ce", 32'(bus.cpu_ce), 32'(c % 12 == 0));
`ifdef NES_CLK_M2_EN
      chk("t1_m2", 32'(bus.m2), 32'(((c - 1) % 12) >= 5));
`endif
    end
    chk("t1_cycles", 32'(bus.cpu_cycles), 32'd4);

    // mode switch: a short revert, then a real A -> B change at cycle 30
    do_reset();
    for (int c = 1; c <= 60; c++) begin
      clk_step();
      e_cpu = (c == 12) || (c == 24) || (c == 36) || (c == 52);
      e_ppu = (c <= 36) ? (c % 4 == 0) : ((c - 36) % 5 == 0);
      chk("t2_cpu_ce", 32'(bus.cpu_ce), 32'(e_cpu));
      chk("t2_ppu_ce", 32'(bus.ppu_ce), 32'(e_ppu));
      chk("t2_mode", 32'(bus.mode_active), 32'(c >= 37));
      if (c == 5)  bus.mode_sel = MODE_PAL;
      if (c == 8)  bus.mode_sel = MODE_NTSC;
      if (c == 30) bus.mode_sel = MODE_PAL;
    end
    chk("t2_cycles", 32'(bus.cpu_cycles), 32'd4);
    #1 rst_n = 1'b0;
    #1;
    chk("t2_arst_mode", 32'(bus.mode_active), 32'd0);
    chk("t2_arst_cycles", 32'(bus.cpu_cycles), 32'd0);

    // pause, single step, run+step together, then reset in the middle of a step
    bus.mode_sel = MODE_NTSC;
    bus.run = 1'b1;
    do_reset();
    for (int c = 1; c <= 97; c++) begin
      clk_step();
      e_cpu = (c == 12) || (c == 24) || (c == 52) || (c == 72) || (c == 84);
      e_ppu = ((c <= 24) && (c % 4 == 0)) || (c == 44) || (c == 48) || (c == 52) ||
              ((c > 60) && (c <= 84) && ((c - 60) % 4 == 0)) || (c == 94);
      e_ack = (c == 52);
      chk("t3_cpu_ce", 32'(bus.cpu_ce), 32'(e_cpu));
      chk("t3_ppu_ce", 32'(bus.ppu_ce), 32'(e_ppu));
      chk("t3_ack", 32'(bus.step_ack), 32'(e_ack));
`ifdef NES_CLK_M2_EN
      if (c <= 24)      chk("t3_m2", 32'(bus.m2), 32'(((c - 1) % 12) >= 5));
      else if (c <= 40) chk("t3_m2_hold", 32'(bus.m2), 32'd1);
      else if (c <= 52) chk("t3_m2_step", 32'(bus.m2), 32'(((c - 41) % 12) >= 5));
      else if (c <= 60) chk("t3_m2_hold", 32'(bus.m2), 32'd1);
`endif
      if (c == 60) chk("t3_cycles_step", 32'(bus.cpu_cycles), 32'd3);
      if (c == 72) chk("t4_cycles_run", 32'(bus.cpu_cycles), 32'd4);
      case (c)
        15: bus.run = 1'b0;
        40: bus.step_req = 1'b1;
        41: bus.step_req = 1'b0;
        45: bus.step_req = 1'b1;
        46: bus.step_req = 1'b0;
        60: begin bus.run = 1'b1; bus.step_req = 1'b1; end
        61: bus.step_req = 1'b0;
        76: bus.run = 1'b0;
        90: bus.step_req = 1'b1;
        91: bus.step_req = 1'b0;
        default: ;
      endcase
    end
    chk("t5_cycles_pre", 32'(bus.cpu_cycles), 32'd5);
    #1 rst_n = 1'b0;
    #1;
    chk("t5_arst_cpu_ce", 32'(bus.cpu_ce), 32'd0);
    chk("t5_arst_ppu_ce", 32'(bus.ppu_ce), 32'd0);
    chk("t5_arst_ack", 32'(bus.step_ack), 32'd0);
    chk("t5_arst_mode", 32'(bus.mode_active), 32'd0);
    chk("t5_arst_cycles", 32'(bus.cpu_cycles), 32'd0);

    // released with run low: RUN after reset drains to the first boundary
    do_reset();
    for (int c = 1; c <= 30; c++) begin
      clk_step();
      chk("t5_cpu_ce", 32'(bus.cpu_ce), 32'(c == 12));
      chk("t5_ppu_ce", 32'(bus.ppu_ce), 32'((c == 4) || (c == 8) || (c == 12)));
    end
    chk("t5_cycles", 32'(bus.cpu_cycles), 32'd1);

    // cpu_cycles wrap on a 4-bit instance
    @(negedge m_clk);
    rst_n_w = 1'b1;
    cyc = 0;
    for (int c = 1; c <= 192; c++) begin
      clk_step();
      if (c == 180) chk("t6_cycles_max", 32'(bus_w.cpu_cycles), 32'd15);
      if (c == 191) chk("t6_cycles_hold", 32'(bus_w.cpu_cycles), 32'd15);
      if (c == 192) begin
        chk("t6_wrap_ce", 32'(bus_w.cpu_ce), 32'd1);
        chk("t6_cycles_wrap", 32'(bus_w.cpu_cycles), 32'd0);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
